// File: rtl/sap_controller_sequencer.sv
// sap_controller_sequencer
// Six-phase ring-counter controller for the 8-bit SAP computer. Decodes the
// IR opcode into the 13-bit control word that steers the W bus each cycle.
// Optional feature: define SAP_JMP_EN to decode opcode 4'h3 as JMP (drives Lp);
// otherwise 4'h3 is a NOP and Lp is held low.
module sap_controller_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [3:0]  opcode,
  output logic [12:0] ctrl,
  output logic [5:0]  tstate,
  output logic        halted
);

  // Control word bit positions
  localparam logic [12:0] CP = 13'h1000;
  localparam logic [12:0] EP = 13'h0800;
  localparam logic [12:0] LM = 13'h0400;
  localparam logic [12:0] CE = 13'h0200;
  localparam logic [12:0] LI = 13'h0100;
  localparam logic [12:0] EI = 13'h0080;
  localparam logic [12:0] LA = 13'h0040;
  localparam logic [12:0] EA = 13'h0020;
  localparam logic [12:0] SU = 13'h0010;
  localparam logic [12:0] EU = 13'h0008;
  localparam logic [12:0] LB = 13'h0004;
  localparam logic [12:0] LO = 13'h0002;
  localparam logic [12:0] LP = 13'h0001;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;
`ifdef SAP_JMP_EN
  localparam logic [3:0] OP_JMP = 4'h3;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_T5   = 3'd5,
    S_T6   = 3'd6,
    S_HALT = 3'd7
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [12:0] w_ctrl;

  // State register; reset forces IDLE without waiting for a clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state: ring advances every cycle, run sampled only in IDLE and T6
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (run) w_next = S_T1;
      S_T1:   w_next = S_T2;
      S_T2:   w_next = S_T3;
      S_T3:   w_next = S_T4;
      S_T4:   w_next = (opcode == OP_HLT) ? S_HALT : S_T5;
      S_T5:   w_next = S_T6;
      S_T6:   w_next = run ? S_T1 : S_IDLE;
      S_HALT: w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  // Control-word decode: fetch is opcode-independent, execute keyed by opcode
  always_comb begin
    w_ctrl = '0;
    case (r_state)
      S_T1: w_ctrl = EP | LM;
      S_T2: w_ctrl = CP;
      S_T3: w_ctrl = CE | LI;
      S_T4: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: w_ctrl = EI | LM;
          OP_OUT:                 w_ctrl = EA | LO;
`ifdef SAP_JMP_EN
          OP_JMP:                 w_ctrl = EI | LP;
`endif
          default:                w_ctrl = '0;
        endcase
      end
      S_T5: begin
        case (opcode)
          OP_LDA:         w_ctrl = CE | LA;
          OP_ADD, OP_SUB: w_ctrl = CE | LB;
          default:        w_ctrl = '0;
        endcase
      end
      S_T6: begin
        case (opcode)
          OP_ADD:  w_ctrl = EU | LA;
          OP_SUB:  w_ctrl = EU | LA | SU;
          default: w_ctrl = '0;
        endcase
      end
      default: w_ctrl = '0;
    endcase
  end

  // Phase and halt status decode
  always_comb begin
    tstate = '0;
    case (r_state)
      S_T1:    tstate = 6'b000001;
      S_T2:    tstate = 6'b000010;
      S_T3:    tstate = 6'b000100;
      S_T4:    tstate = 6'b001000;
      S_T5:    tstate = 6'b010000;
      S_T6:    tstate = 6'b100000;
      default: tstate = '0;
    endcase
  end

  assign halted = (r_state == S_HALT);

`ifdef SAP_JMP_EN
  assign ctrl = w_ctrl;
`else
  // Without JMP nothing may ever load the PC
  assign ctrl = w_ctrl & ~LP;
`endif

endmodule

// File: tb/tb_sap_controller_sequencer.sv
// Bench for sap_controller_sequencer: expected phase/control words are queued
// as each cycle's stimulus is applied and compared just after the clock edge.
module tb_sap_controller_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [3:0]  opcode;
  logic [12:0] ctrl;
  logic [5:0]  tstate;
  logic        halted;

  sap_controller_sequencer dut (
    .clk    (clk),
    .reset  (reset),
    .run    (run),
    .opcode (opcode),
    .ctrl   (ctrl),
    .tstate (tstate),
    .halted (halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [12:0] c;
    logic [5:0]  t;
    logic        h;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

`ifdef SAP_JMP_EN
  localparam logic [12:0] JMP_T4 = 13'h0081;
`else
  localparam logic [12:0] JMP_T4 = 13'h0000;
`endif

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Apply inputs at a falling edge, queue the state expected after the next rise
  task automatic cyc(input logic r, input logic [3:0] op,
                     input logic [12:0] c, input logic [5:0] t, input logic h);
    exp_t e;
    run    = r;
    opcode = op;
    e.c = c;
    e.t = t;
    e.h = h;
    sb.push_back(e);
    @(negedge clk);
  endtask

  // One full instruction; opcode is scrambled during fetch to show it is ignored
  task automatic instr(input logic [3:0] op, input logic [12:0] e4,
                       input logic [12:0] e5, input logic [12:0] e6);
    cyc(1'b1, ~op, 13'h0C00, 6'b000001, 1'b0);
    cyc(1'b1, ~op, 13'h1000, 6'b000010, 1'b0);
    cyc(1'b0, op,  13'h0300, 6'b000100, 1'b0);
    cyc(1'b1, op,  e4,       6'b001000, 1'b0);
    cyc(1'b0, op,  e5,       6'b010000, 1'b0);
    cyc(1'b1, op,  e6,       6'b100000, 1'b0);
  endtask

  // Compare outputs shortly after each rising edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    chk("one_bus_driver", 32'($countones(ctrl & 13'h0AA8) <= 1), 32'd1);
`ifndef SAP_JMP_EN
    chk("lp_tied_low", 32'(ctrl[0]), 32'd0);
`endif
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("ctrl",   32'(ctrl),   32'(e.c));
      chk("tstate", 32'(tstate), 32'(e.t));
      chk("halted", 32'(halted), 32'(e.h));
    end
  end

  initial begin
    reset  = 1'b1;
    run    = 1'b1;
    opcode = 4'h0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ctrl",   32'(ctrl),   32'd0);
    chk("rst_tstate", 32'(tstate), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    reset = 1'b0;

    // Back-to-back instructions with run held
    instr(4'h0, 13'h0480, 13'h0240, 13'h0000);   // LDA
    instr(4'h1, 13'h0480, 13'h0204, 13'h0048);   // ADD
    instr(4'h2, 13'h0480, 13'h0204, 13'h0058);   // SUB
    instr(4'h5, 13'h0000, 13'h0000, 13'h0000);   // NOP
    instr(4'h3, JMP_T4,   13'h0000, 13'h0000);   // JMP / NOP
    instr(4'h0, 13'h0480, 13'h0240, 13'h0000);   // LDA, then drop run
    cyc(1'b0, 4'h0, 13'h0000, 6'b000000, 1'b0);
    cyc(1'b0, 4'h0, 13'h0000, 6'b000000, 1'b0);

    // ADD interrupted by asynchronous reset in T5
    cyc(1'b1, 4'h1, 13'h0C00, 6'b000001, 1'b0);
    cyc(1'b1, 4'h1, 13'h1000, 6'b000010, 1'b0);
    cyc(1'b1, 4'h1, 13'h0300, 6'b000100, 1'b0);
    cyc(1'b1, 4'h1, 13'h0480, 6'b001000, 1'b0);
    cyc(1'b1, 4'h1, 13'h0204, 6'b010000, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_ctrl",   32'(ctrl),   32'd0);
    chk("async_rst_tstate", 32'(tstate), 32'd0);
    chk("async_rst_halted", 32'(halted), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // OUT then HLT; run toggles while halted
    instr(4'hE, 13'h0022, 13'h0000, 13'h0000);
    cyc(1'b1, 4'h0, 13'h0C00, 6'b000001, 1'b0);
    cyc(1'b1, 4'h0, 13'h1000, 6'b000010, 1'b0);
    cyc(1'b1, 4'hF, 13'h0300, 6'b000100, 1'b0);
    cyc(1'b1, 4'hF, 13'h0000, 6'b001000, 1'b0);
    for (int i = 0; i < 20; i++)
      cyc(i[0], 4'hF, 13'h0000, 6'b000000, 1'b1);

    // Only reset leaves HALT
    reset = 1'b1;
    #1;
    chk("halt_rst_halted", 32'(halted), 32'd0);
    chk("halt_rst_ctrl",   32'(ctrl),   32'd0);
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b0, 4'h0, 13'h0000, 6'b000000, 1'b0);
    cyc(1'b0, 4'h0, 13'h0000, 6'b000000, 1'b0);
    instr(4'h2, 13'h0480, 13'h0204, 13'h0058);
    cyc(1'b0, 4'h0, 13'h0000, 6'b000000, 1'b0);

    @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sap_controller_sequencer.md
# sap_controller_sequencer

Controller-sequencer for the 8-bit SAP computer. It runs a six-phase ring counter (T1..T6) and decodes the 4-bit opcode held by the instruction register. Each cycle it drives the 13-bit control word that gates the program counter, MAR, RAM, instruction register, accumulator, ALU, B and output registers onto and off the W bus. It sits between the instruction register's opcode output and every datapath load/enable pin.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all state changes occur on its rising edge.
- reset  in  1  reset, asynchronous, active-high.
- run  in  1  start/continue request, level-sensitive.
- opcode  in  4  opcode from the instruction register, read combinationally during T4..T6.
- ctrl  out  13  control word. Bit map:
  - [12] Cp: increment PC
  - [11] Ep: PC to bus
  - [10] Lm: load MAR
  - [9] CE: RAM to bus
  - [8] Li: load IR
  - [7] Ei: IR operand to bus
  - [6] La: load A
  - [5] Ea: A to bus
  - [4] Su: subtract
  - [3] Eu: ALU to bus
  - [2] Lb: load B
  - [1] Lo: load OUT
  - [0] Lp: load PC
- tstate  out  6  one-hot phase (bit0 = T1 .. bit5 = T6); 0 in IDLE/HALT.
- halted  out  1  high while in HALT.

## Operation
- States: IDLE, T1, T2, T3, T4, T5, T6, HALT.
- Reset puts the block in IDLE with ctrl=0, tstate=0, halted=0.
- Transitions:
  - IDLE -> T1 when run=1.
  - T1 -> T2 -> T3 -> T4 unconditionally.
  - T4 -> HALT if opcode=HLT (4'hF); otherwise T4 -> T5 -> T6.
  - T6 -> T1 if run=1, else IDLE. An instruction in flight always completes; run is sampled only in IDLE and T6.
  - HALT exits only via reset.
- Fetch phases, all opcodes:
  - T1: Ep, Lm.
  - T2: Cp.
  - T3: CE, Li.
- Execute phases by opcode (phases not listed drive ctrl=0):
  - LDA 4'h0: T4 Ei, Lm; T5 CE, La.
  - ADD 4'h1: T4 Ei, Lm; T5 CE, Lb; T6 Eu, La.
  - SUB 4'h2: as ADD, with Su also asserted in T6.
  - OUT 4'hE: T4 Ea, Lo.
  - HLT 4'hF: T4 drives ctrl=0, next state HALT.
  - Any other opcode: NOP, ctrl=0 in T4..T6.
- Invariant: at most one bus driver (Ep, CE, Ei, Ea, Eu) is asserted in any cycle.
- ctrl, tstate and halted are pure combinational decodes of the state register and opcode, with no output registers.

## Timing
- ctrl is valid from the rising edge that enters a phase. Datapath registers capture on the next rising edge, so each micro-op takes exactly one cycle.
- Instruction length is fixed at 6 cycles, HLT included up to T4. Back-to-back instructions run with zero idle cycles while run=1.
- First T1 is entered on the first rising edge with run=1 after reset deassertion.
- Reset asserted mid-instruction forces IDLE and ctrl=0 immediately, with no clock needed. Partially executed micro-ops are not undone.
- opcode changes during T1..T3 are ignored. opcode must be stable from the T3->T4 edge through T6; the IR loads at the end of T3.

## Configuration
- SAP_JMP_EN defined:
  - Opcode 4'h3 decodes as JMP: T4 Ei, Lp; T5 and T6 ctrl=0.
  - Lp is driven only by JMP.
- SAP_JMP_EN undefined:
  - 4'h3 is a NOP.
  - ctrl[0] (Lp) is tied to 0.

## Test plan
- Reset check: assert reset with run=1 -> ctrl=13'h0000, tstate=0, halted=0. Release reset -> next edge tstate=6'b000001 and ctrl=13'h0C00.
- LDA (opcode 0): per-cycle ctrl 0C00, 1000, 0300, 0480, 0240, 0000. Then T1 again if run=1; IDLE with ctrl=0 if run=0.
- ADD/SUB (opcode 1/2):
  - T5 = 13'h0204.
  - T6 = 13'h0048 for ADD and 13'h0058 for SUB.
  - Checker confirms at most one bus driver in every cycle.
- OUT then HLT (opcode E, then F):
  - OUT T4 = 13'h0022.
  - HLT: after its T4, halted=1 and ctrl=0 for 20 cycles with run toggling.
  - Only reset clears halted.
- Reset pulsed asynchronously mid-T5 of ADD -> ctrl=0 and tstate=0 before the next edge. Fresh fetch begins at T1 after release.
- JMP (opcode 3), both builds:
  - With SAP_JMP_EN: T4 = 13'h0081.
  - Without SAP_JMP_EN: T4..T6 = 0 and ctrl[0] is never 1.
